// File: rtl/io_cfg_pkg.sv
// Shared types and size helpers for the IO configuration-chain loader.
package io_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_MARK,
    ST_DATA,
    ST_FIN
  } state_t;

  // Words needed to cover the whole chain
  function automatic int calc_nw(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  function automatic int calc_cw(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Bits of the final word that actually land in the chain
  function automatic int calc_last_bits(input int chain_len, input int word_w);
    return ((chain_len - 1) % word_w) + 1;
  endfunction

endpackage

// File: rtl/io_cfg_word_serializer.sv
// One-word buffer that accepts configuration words and presents them LSB-first.
module io_cfg_word_serializer
  import io_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              i_clr,
  input  logic              i_active,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_shift,
  output logic              o_head
);

  localparam int NW        = calc_nw(CHAIN_LEN, WORD_W);
  localparam int LAST_BITS = calc_last_bits(CHAIN_LEN, WORD_W);
  localparam int BCW       = $clog2(WORD_W + 1);
  localparam int NCW       = $clog2(NW + 1);

  logic [WORD_W-1:0] r_buf;
  logic [BCW-1:0]    r_bits;
  logic [NCW-1:0]    r_words;

  logic w_empty;
  logic w_take;

  assign w_empty = (r_bits == '0);
  assign o_ready = i_active & w_empty & (r_words < NCW'(NW));
  assign w_take  = o_ready & i_valid;
  assign o_shift = i_active & ~w_empty;
  assign o_head  = r_buf[0];

  // A load and a shift never coincide: loading needs an empty buffer
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_buf   <= '0;
      r_bits  <= '0;
      r_words <= '0;
    end else if (i_clr) begin
      r_buf   <= '0;
      r_bits  <= '0;
      r_words <= '0;
    end else if (w_take) begin
      r_buf   <= i_word;
      r_bits  <= (r_words == NCW'(NW - 1)) ? BCW'(LAST_BITS) : BCW'(WORD_W);
      r_words <= r_words + NCW'(1);
    end else if (o_shift) begin
      r_buf   <= r_buf >> 1;
      r_bits  <= r_bits - BCW'(1);
    end
  end

endmodule

// File: rtl/io_ccff_cfg_loader.sv
// Loads the IO-tile configuration flip-flop chain: flush, marker, data, with
// a marker-based chain length/connectivity self-check.
module io_ccff_cfg_loader
  import io_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              CW       = calc_cw(CHAIN_LEN);
  localparam logic [CW-1:0]   LAST_CNT = CW'(CHAIN_LEN - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic w_active;
  logic w_clr;
  logic w_shift;
  logic w_ser_head;

  assign w_active = (r_state == ST_DATA);
  assign w_clr    = (r_state == ST_IDLE);

  io_cfg_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W)
  ) u_ser (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .i_clr        (w_clr),
    .i_active     (w_active),
    .i_word       (cfg_word),
    .i_valid      (cfg_valid),
    .o_ready      (cfg_ready),
    .o_shift      (w_shift),
    .o_head       (w_ser_head)
  );

  // Chain drive is decoded from registered state only
  always_comb begin
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    case (r_state)
      ST_FLUSH: ccff_en = 1'b1;
      ST_MARK: begin
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
      end
      ST_DATA: begin
        ccff_en   = w_shift;
        ccff_head = w_shift & w_ser_head;
      end
      default: begin
        ccff_en   = 1'b0;
        ccff_head = 1'b0;
      end
    endcase
  end

  // r_cnt counts flush cycles, then data shifts; on data shift N (N = r_cnt+1)
  // the marker must reach the tail exactly when N == CHAIN_LEN.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_start) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_MARK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_MARK: r_state <= ST_DATA;
        ST_DATA: begin
          if (w_shift) begin
            if (ccff_tail != (r_cnt == LAST_CNT)) r_err <= 1'b1;
            if (r_cnt == LAST_CNT) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_io_ccff_cfg_loader.sv
// Scoreboard bench for io_ccff_cfg_loader with a behavioural chain model.
module tb_io_ccff_cfg_loader;

  localparam int CL  = 10;
  localparam int WW  = 4;
  localparam int NW  = (CL + WW - 1) / WW;
  localparam int CL7 = 7;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          cfg_start = 1'b0;
  logic [WW-1:0] cfg_word  = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready, ccff_head, ccff_en, ccff_tail, busy, done, err;

  logic          start7 = 1'b0;
  logic [7:0]    word7  = '0;
  logic          valid7 = 1'b0;
  logic          ready7, head7, en7, tail7, busy7, done7, err7;

  always #5 clk = ~clk;

  io_ccff_cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) u_dut (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(cfg_start),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .err(err)
  );

  io_ccff_cfg_loader #(.CHAIN_LEN(CL7), .WORD_W(8)) u_dut7 (
    .prog_clk(clk), .prog_reset_n(rst_n), .cfg_start(start7),
    .cfg_word(word7), .cfg_valid(valid7), .cfg_ready(ready7),
    .ccff_head(head7), .ccff_en(en7), .ccff_tail(tail7),
    .busy(busy7), .done(done7), .err(err7)
  );

  // Chain models: shift register of selectable length fed by the head
  logic [15:0] chain   = '0;
  int          chain_l = CL;
  logic [6:0]  chain7  = '0;
  always @(posedge clk) begin
    if (ccff_en) chain  <= {chain[14:0], ccff_head};
    if (en7)     chain7 <= {chain7[5:0], head7};
  end
  assign ccff_tail = chain[chain_l-1];
  assign tail7     = chain7[6];

  int          vectors     = 0;
  int          miscompares = 0;
  bit          exp_head_q[$];
  logic [15:0] exp_chain   = '0;
  bit          exp_err     = 1'b0;
  bit          check_chain = 1'b0;
  bit          mon_en      = 1'b0;
  bit          prev_done   = 1'b0;
  int          exp_busy    = 0;
  int          busy_cnt    = 0;
  int          done_seen   = 0;
  logic [WW-1:0] words [NW];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expected head bit per chain shift, checks at done
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (busy) busy_cnt++;
        if (ccff_en) begin
          if (exp_head_q.size() == 0) check("head_extra_shift", 1, 0);
          else check("head_bit", int'(ccff_head), int'(exp_head_q.pop_front()));
        end
        if (done) begin
          check("done_width", int'(prev_done), 0);
          check("busy_cycles", busy_cnt, exp_busy);
          check("head_bits_left", exp_head_q.size(), 0);
          check("err_at_fin", int'(err), int'(exp_err));
          check("en_at_fin", int'(ccff_en), 0);
          if (check_chain) check("chain_contents", int'(chain[CL-1:0]), int'(exp_chain[CL-1:0]));
          busy_cnt = 0;
          done_seen++;
        end
      end
      prev_done = done;
    end
  end

  task automatic do_load(input int L, input int stall_word, input int stall_n, input bit poke);
    int waitc;
    @(posedge clk);
    chain_l = L;
    exp_head_q.delete();
    for (int i = 0; i < CL; i++) exp_head_q.push_back(1'b0);
    exp_head_q.push_back(1'b1);
    for (int b = 0; b < CL; b++) begin
      logic [WW-1:0] w;
      w = words[b / WW];
      exp_head_q.push_back(w[b % WW]);
      exp_chain[CL-1-b] = w[b % WW];
    end
    exp_err     = (L != CL);
    check_chain = (L == CL);
    exp_busy    = 2 * CL + 2 + NW + stall_n;
    #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", int'(busy), 1);
    check("err_cleared_on_start", int'(err), 0);
    for (int k = 0; k < NW; k++) begin
      if (k == stall_word && stall_n > 0) begin
        cfg_valid = 1'b0;
        waitc = 0;
        while (!cfg_ready && waitc < 100) begin @(negedge clk); waitc++; end
        if (!cfg_ready) check("stall_ready_timeout", 0, 1);
        for (int s = 0; s < stall_n; s++) begin
          if (s > 0) @(negedge clk);
          check("stall_ready", int'(cfg_ready), 1);
          check("stall_en", int'(ccff_en), 0);
        end
        @(posedge clk); #1;
      end
      cfg_valid = 1'b1;
      cfg_word  = words[k];
      waitc = 0;
      do begin
        @(negedge clk);
        waitc++;
        cfg_start = poke && ((k == 0 && waitc == 3) || (k == 1 && waitc == 2));
      end while (!cfg_ready && waitc < 100);
      if (!cfg_ready) check("ready_timeout", 0, 1);
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    cfg_valid = 1'b0;
    waitc = 0;
    while (!done && waitc < 200) begin @(negedge clk); waitc++; end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic reset_mid_load();
    int waitc;
    int ens;
    mon_en = 1'b0;
    @(posedge clk);
    chain_l = CL;
    #1 cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_word  = words[0];
    ens = 0;
    waitc = 0;
    while (ens < CL + 4 && waitc < 200) begin
      @(negedge clk);
      waitc++;
      if (ccff_en) ens++;
    end
    if (ens != CL + 4) check("reset_setup_timeout", ens, CL + 4);
    @(posedge clk); #1 rst_n = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_en", int'(ccff_en), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cfg_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    exp_head_q.delete();
    busy_cnt = 0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    mon_en = 1'b1;
  endtask

  task automatic run7();
    int waitc, dshift, rdy, bcnt, en_cnt, ones;
    @(posedge clk); #1 start7 = 1'b1;
    @(posedge clk); #1 start7 = 1'b0;
    valid7 = 1'b1;
    word7  = 8'hFF;
    dshift = 0; rdy = 0; bcnt = 0; en_cnt = 0; ones = 0; waitc = 0;
    while (!done7 && waitc < 100) begin
      @(negedge clk);
      waitc++;
      if (busy7) bcnt++;
      if (ready7) rdy++;
      if (en7) begin
        en_cnt++;
        if (en_cnt > CL7 + 1) begin
          dshift++;
          ones += int'(head7);
        end
      end
    end
    valid7 = 1'b0;
    check("w8_done_seen", int'(done7), 1);
    check("w8_data_shifts", dshift, CL7);
    check("w8_data_ones", ones, CL7);
    check("w8_ready_cycles", rdy, 1);
    check("w8_busy_cycles", bcnt, 2 * CL7 + 3);
    check("w8_err", int'(err7), 0);
    check("w8_chain", int'(chain7), 7'h7F);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_state_ready", int'(cfg_ready), 0);
    check("rst_state_head", int'(ccff_head), 0);
    check("rst_state_en", int'(ccff_en), 0);
    check("rst_state_busy", int'(busy), 0);
    check("rst_state_done", int'(done), 0);
    check("rst_state_err", int'(err), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    words = '{4'h5, 4'hA, 4'h3};
    do_load(CL, -1, 0, 1'b0);
    do_load(CL - 1, -1, 0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("err_sticky_idle", int'(err), 1);
      check("idle_busy", int'(busy), 0);
    end
    do_load(CL, 1, 5, 1'b0);

    for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
    do_load(CL, -1, 0, 1'b1);
    for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
    do_load(CL, int'($urandom_range(1, NW - 1)), int'($urandom_range(1, 6)), 1'b0);

    reset_mid_load();
    for (int k = 0; k < NW; k++) words[k] = WW'($urandom);
    do_load(CL, -1, 0, 1'b0);

    run7();
    repeat (2) @(negedge clk);
    check("done_count", done_seen, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
